intr_controller: RTL and testbench
==================================

Name: intr_controller

Overview:
Sequences hardware-interrupt entry for the 8-bit pipelined CPU. Synchronises the external INTR_in line and latches a pending request. On acceptance it stalls fetch and waits for the pipeline to drain, pushes the return PC and flags to the stack through the shared data-memory port, reads the handler address from the vector location and forces a PC load. It sits between the CPU top level, the fetch/PC stage, the stack-pointer register and the data-memory port arbiter.

Parameters:
VEC_ADDR, 8'h01, data-memory address that holds the interrupt handler address
SYNC_STAGES, 2, number of flops in the INTR_in synchroniser (minimum 2)

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
INTR_in  input  1  external interrupt request, asynchronous; rising edge is significant
int_en  input  1  global interrupt enable from the flags/control unit
pipe_empty  input  1  high when no valid instruction remains in decode/execute/memory/writeback
pc_in  input  8  address of the next instruction that would be fetched (return address)
flags_in  input  4  current CCR flags {V,C,N,Z}
sp_in  input  8  current stack pointer
rti_done  input  1  one-cycle pulse when an RTI retires
stall_fetch  output  1  hold PC and inject NOPs into fetch
mem_req  output  1  data-memory port request
mem_we  output  1  write enable qualifying mem_req
mem_addr  output  8  data-memory address
mem_wdata  output  8  data-memory write data
mem_gnt  input  1  port granted; the access completes in this cycle
mem_rdata  input  8  read data, valid in the cycle mem_gnt is high
sp_dec  output  1  one-cycle pulse: decrement SP
pc_load  output  1  one-cycle pulse: load PC from pc_load_val
pc_load_val  output  8  handler address
in_service  output  1  handler active, nesting blocked

Behaviour:
- Reset (RST=1 at a clock edge): state IDLE; synchroniser, pending and in_service cleared; all outputs 0. This applies mid-sequence: any partial push is abandoned and the request is discarded. INTR_in edges sampled while RST=1 are ignored.
- Synchroniser: INTR_in passes through SYNC_STAGES flops. A rising edge on the last stage sets the pending bit on the next edge. The request queue is one deep: further edges while pending=1 are lost.
- Pending is cleared on entry to JUMP. If a new rising edge is detected in the same cycle, the new edge wins and pending stays 1.
- FSM states: IDLE, STALL, PUSH_PC, PUSH_FLG, RD_VEC, JUMP.
- IDLE: if pending & int_en & !in_service, go to STALL; otherwise stay. Pending is retained while int_en=0 or in_service=1.
- STALL: stall_fetch=1. If pipe_empty=1, go to PUSH_PC. No timeout.
- PUSH_PC: stall_fetch=1, mem_req=1, mem_we=1, mem_addr=sp_in, mem_wdata=pc_in. Hold until mem_gnt. On the grant cycle sp_dec=1 and the state goes to PUSH_FLG.
- PUSH_FLG: as PUSH_PC, with mem_wdata={4'b0,flags_in} and mem_addr=sp_in (already decremented). On grant, sp_dec=1 and go to RD_VEC.
- RD_VEC: stall_fetch=1, mem_req=1, mem_we=0, mem_addr=VEC_ADDR. On grant, register mem_rdata into pc_load_val and go to JUMP.
- JUMP: pc_load=1 and stall_fetch=1 for one cycle. Set in_service, then go to IDLE. pc_load_val holds its value until the next RD_VEC grant.
- in_service clears on rti_done. If rti_done and the JUMP entry occur together, in_service ends at 1.
- mem_addr and mem_wdata are 0 whenever mem_req=0. sp_dec and pc_load never assert outside the cycles listed above.
- Latency with pipe_empty=1 and mem_gnt=1 tied high: INTR_in first sampled high at edge N gives pc_load=1 in the cycle after edge N+SYNC_STAGES+5 (N+7 for the defaults). Each extra cycle without mem_gnt or pipe_empty adds exactly one cycle.

Decomposition:
- Shared package cpu_pkg: FSM state encoding (3-bit localparams), VEC_ADDR default, and the flag bit positions.
- One sub-module, intr_sync_edge: the SYNC_STAGES synchroniser plus rising-edge detect, with CLK/RST. It is reused for any future external lines.

Test Plan:
- Basic entry: pc_in=8'h2A, flags_in=4'b0101, sp_in=8'hFF, mem_rdata=8'h80, gnt and pipe_empty tied 1, pulse INTR_in -> writes 8'h2A@FF then 8'h05@FE, two sp_dec pulses, read @01, pc_load=1 with pc_load_val=8'h80 exactly 7 cycles after sampling, in_service=1.
- Drain wait: pipe_empty=0 for 4 cycles after acceptance -> stall_fetch held high, mem_req=0 throughout; PUSH_PC begins the cycle after pipe_empty rises.
- Grant stalls: mem_gnt low 3 cycles in PUSH_PC and 2 cycles in RD_VEC -> address and data stable while waiting, no sp_dec until grant, total latency +5 cycles.
- Masking/nesting: int_en=0 during the INTR pulse, raised 10 cycles later -> entry starts then. A second INTR arriving while in_service=1 stays pending until rti_done, then re-enters.
- Reset mid-op: RST=1 during PUSH_FLG -> next cycle all outputs 0, pending=0, in_service=0; no pc_load ever follows.
- Double edge: two INTR pulses before acceptance -> exactly one entry sequence. A pulse detected in the same cycle as JUMP -> a second entry after rti_done.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt FSM state encoding, vector address default, CCR flag bit positions.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_STALL    = 3'd1;
  localparam logic [2:0] ST_PUSH_PC  = 3'd2;
  localparam logic [2:0] ST_PUSH_FLG = 3'd3;
  localparam logic [2:0] ST_RD_VEC   = 3'd4;
  localparam logic [2:0] ST_JUMP     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_STALL    = ST_STALL,
    S_PUSH_PC  = ST_PUSH_PC,
    S_PUSH_FLG = ST_PUSH_FLG,
    S_RD_VEC   = ST_RD_VEC,
    S_JUMP     = ST_JUMP
  } intr_state_t;

  localparam logic [7:0] VEC_ADDR_DEF = 8'h01;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  // Stack image of the CCR: flags in the low nibble, upper nibble zero.
  function automatic logic [7:0] flags_byte(input logic [3:0] f);
    return {4'b0000, f[FLG_V], f[FLG_C], f[FLG_N], f[FLG_Z]};
  endfunction

endpackage

// File: rtl/intr_controller_if.sv
// Data-memory port as seen by the interrupt sequencer; the access completes in the cycle mem_gnt is high.
interface intr_controller_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_gnt;
  logic [7:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/intr_sync_edge.sv
// STAGES-flop synchroniser for an asynchronous line plus rising-edge detect on the last stage.
// o_rise is combinational from flops and high for one cycle per synchronised 0->1 transition.
module intr_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_last <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_last;

endmodule

// File: rtl/intr_controller.sv
// Interrupt entry sequencer: stall fetch, drain pipe, push PC and flags, read vector, load PC.
// Pulse-to-pc_load latency is SYNC_STAGES+5 cycles; waits indefinitely on pipe_empty and mem_gnt.
module intr_controller
  import cpu_pkg::*;
#(
  parameter logic [7:0] VEC_ADDR    = VEC_ADDR_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      INTR_in,
  input  logic                      int_en,
  input  logic                      pipe_empty,
  input  logic [7:0]                pc_in,
  input  logic [3:0]                flags_in,
  input  logic [7:0]                sp_in,
  input  logic                      rti_done,
  output logic                      stall_fetch,
  intr_controller_if.master         mem,
  output logic                      sp_dec,
  output logic                      pc_load,
  output logic [7:0]                pc_load_val,
  output logic                      in_service
);

  intr_state_t r_state;
  intr_state_t w_next;
  logic        r_pending;
  logic        r_in_service;
  logic [7:0]  r_pc_load_val;
  logic        w_rise;
  logic        w_enter_jump;
  logic        w_stall;
  logic        w_req;
  logic        w_we;
  logic [7:0]  w_addr;
  logic [7:0]  w_wdata;
  logic        w_sp_dec;
  logic        w_pc_load;

  intr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .i_async (INTR_in),
    .o_rise  (w_rise)
  );

  // A fresh edge in the JUMP-entry cycle outranks the clear, so it is not lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_in_service  <= 1'b0;
      r_pc_load_val <= 8'h00;
    end else begin
      r_state      <= w_next;
      r_pending    <= w_rise | (r_pending & ~w_enter_jump);
      r_in_service <= w_enter_jump | (r_in_service & ~rti_done);
      if (w_enter_jump) begin
        r_pc_load_val <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = 8'h00;
    w_wdata      = 8'h00;
    w_sp_dec     = 1'b0;
    w_pc_load    = 1'b0;
    w_enter_jump = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending && int_en && !r_in_service) w_next = S_STALL;
      end
      S_STALL: begin
        w_stall = 1'b1;
        if (pipe_empty) w_next = S_PUSH_PC;
      end
      S_PUSH_PC: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = sp_in;
        w_wdata = pc_in;
        if (mem.mem_gnt) begin
          w_sp_dec = 1'b1;
          w_next   = S_PUSH_FLG;
        end
      end
      S_PUSH_FLG: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = sp_in;
        w_wdata = flags_byte(flags_in);
        if (mem.mem_gnt) begin
          w_sp_dec = 1'b1;
          w_next   = S_RD_VEC;
        end
      end
      S_RD_VEC: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_addr  = VEC_ADDR;
        if (mem.mem_gnt) begin
          w_enter_jump = 1'b1;
          w_next       = S_JUMP;
        end
      end
      S_JUMP: begin
        w_stall   = 1'b1;
        w_pc_load = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign stall_fetch   = w_stall;
  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = w_wdata;
  assign sp_dec        = w_sp_dec;
  assign pc_load       = w_pc_load;
  assign pc_load_val   = r_pc_load_val;
  assign in_service    = r_in_service;

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed table for the basic entry, directed corner sequences,
// and random stimulus checked every cycle against a behavioural model of the entry rules.
module tb_intr_controller;

  localparam int SYNC = 2;
  localparam logic [7:0] VEC = 8'h01;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INTR_in = 1'b0;
  logic       int_en = 1'b1;
  logic       pipe_empty = 1'b1;
  logic [7:0] pc_in = 8'h2A;
  logic [3:0] flags_in = 4'b0101;
  logic [7:0] sp_in = 8'hFF;
  logic       rti_done = 1'b0;
  logic       stall_fetch;
  logic       sp_dec;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       in_service;

  intr_controller_if mif ();

  intr_controller #(.VEC_ADDR(VEC), .SYNC_STAGES(SYNC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .INTR_in     (INTR_in),
    .int_en      (int_en),
    .pipe_empty  (pipe_empty),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .sp_in       (sp_in),
    .rti_done    (rti_done),
    .stall_fetch (stall_fetch),
    .mem         (mif),
    .sp_dec      (sp_dec),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .in_service  (in_service)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n_pcload = 0;
  int n_stall = 0;
  logic env_dec = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which step of the entry sequence we are in (0 none, 1 awaiting drain,
  // 2 pushing PC, 3 pushing flags, 4 reading vector, 5 loading PC) plus INTR_in sample history.
  logic       m_hist [SYNC+1] = '{default: 1'b0};
  bit         m_pending = 0;
  bit         m_insvc = 0;
  int         m_step = 0;
  logic [7:0] m_pcv = 8'h00;

  task automatic check_model();
    bit pushing;
    pushing = (m_step == 2) || (m_step == 3);
    chk("stall_fetch", stall_fetch, m_step != 0);
    chk("mem_req", mif.mem_req, m_step >= 2 && m_step <= 4);
    chk("mem_we", mif.mem_we, pushing);
    chk("mem_addr", mif.mem_addr, pushing ? sp_in : (m_step == 4 ? VEC : 8'h00));
    chk("mem_wdata", mif.mem_wdata, m_step == 2 ? pc_in : (m_step == 3 ? {4'b0, flags_in} : 8'h00));
    chk("sp_dec", sp_dec, pushing && mif.mem_gnt);
    chk("pc_load", pc_load, m_step == 5);
    chk("pc_load_val", pc_load_val, m_pcv);
    chk("in_service", in_service, m_insvc);
  endtask

  task automatic model_advance();
    bit rise, enter_jump;
    int nstep;
    if (RST) begin
      m_step = 0; m_pending = 0; m_insvc = 0; m_pcv = 8'h00;
      for (int i = 0; i <= SYNC; i++) m_hist[i] = 1'b0;
      return;
    end
    rise = m_hist[SYNC-1] && !m_hist[SYNC];
    enter_jump = (m_step == 4) && mif.mem_gnt;
    nstep = m_step;
    case (m_step)
      0: if (m_pending && int_en && !m_insvc) nstep = 1;
      1: if (pipe_empty) nstep = 2;
      2, 3, 4: if (mif.mem_gnt) nstep = m_step + 1;
      default: nstep = 0;
    endcase
    m_pending = rise || (m_pending && !enter_jump);
    m_insvc = enter_jump || (m_insvc && !rti_done);
    if (enter_jump) m_pcv = mif.mem_rdata;
    m_step = nstep;
    for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = INTR_in;
  endtask

  task automatic neg_half();
    @(negedge CLK);
    check_model();
    if (pc_load === 1'b1) n_pcload++;
    if (stall_fetch === 1'b1) n_stall++;
    env_dec = sp_dec;
  endtask

  task automatic pos_half();
    model_advance();
    @(posedge CLK);
    #1;
    if (env_dec) sp_in = sp_in - 8'd1;
  endtask

  task automatic cyc();
    neg_half();
    pos_half();
  endtask

  // One entry attempt; row k of the run drives the listed pulses, enables and wait counts.
  task automatic entry_run(input int p1, input int p2, input int en_row, input int drain,
                           input int gpc, input int gvec, input int rti_row, input int budget,
                           output int k_pl);
    int cdr = 0, cpc = 0, cvec = 0;
    k_pl = -1;
    for (int k = 0; k < budget; k++) begin
      INTR_in  = (k == p1) || (k == p2);
      int_en   = (k >= en_row);
      rti_done = (k == rti_row);
      pipe_empty = 1'b1;
      if (m_step == 1 && cdr < drain) begin pipe_empty = 1'b0; cdr++; end
      mif.mem_gnt = 1'b1;
      if (m_step == 2 && cpc < gpc) begin mif.mem_gnt = 1'b0; cpc++; end
      if (m_step == 4 && cvec < gvec) begin mif.mem_gnt = 1'b0; cvec++; end
      neg_half();
      if (pc_load === 1'b1 && k_pl < 0) k_pl = k;
      pos_half();
    end
    INTR_in = 1'b0; rti_done = 1'b0; int_en = 1'b1; pipe_empty = 1'b1; mif.mem_gnt = 1'b1;
  endtask

  typedef struct {
    logic       intr;
    logic       stall, req, we;
    logic [7:0] addr, wdata;
    logic       spd, pcl;
    logic [7:0] pcv;
    logic       ins;
  } vec_t;

  function automatic vec_t mkv(logic intr, logic st, logic rq, logic we, logic [7:0] a,
                               logic [7:0] d, logic sd, logic pl, logic [7:0] pv, logic ins);
    vec_t v;
    v.intr = intr; v.stall = st; v.req = rq; v.we = we; v.addr = a; v.wdata = d;
    v.spd = sd; v.pcl = pl; v.pcv = pv; v.ins = ins;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    int first_pl, k, k2, n0, s0, rst_row;
    mif.mem_gnt = 1'b1;
    mif.mem_rdata = 8'h80;

    tbl[0] = mkv(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    tbl[1] = mkv(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    tbl[2] = mkv(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    tbl[3] = mkv(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    tbl[4] = mkv(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    tbl[5] = mkv(0, 1, 1, 1, 8'hFF, 8'h2A, 1, 0, 8'h00, 0);
    tbl[6] = mkv(0, 1, 1, 1, 8'hFE, 8'h05, 1, 0, 8'h00, 0);
    tbl[7] = mkv(0, 1, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 0);
    tbl[8] = mkv(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h80, 1);
    tbl[9] = mkv(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h80, 1);

    @(posedge CLK); #1;
    cyc();
    cyc();
    RST = 1'b0;
    cyc();

    // Basic entry, table driven.
    sp_in = 8'hFF;
    first_pl = -1;
    for (int i = 0; i < 10; i++) begin
      INTR_in = tbl[i].intr;
      neg_half();
      chk($sformatf("tbl%0d_stall", i), stall_fetch, tbl[i].stall);
      chk($sformatf("tbl%0d_req", i), mif.mem_req, tbl[i].req);
      chk($sformatf("tbl%0d_we", i), mif.mem_we, tbl[i].we);
      chk($sformatf("tbl%0d_addr", i), mif.mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_wdata", i), mif.mem_wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_sp_dec", i), sp_dec, tbl[i].spd);
      chk($sformatf("tbl%0d_pc_load", i), pc_load, tbl[i].pcl);
      chk($sformatf("tbl%0d_pc_load_val", i), pc_load_val, tbl[i].pcv);
      chk($sformatf("tbl%0d_in_service", i), in_service, tbl[i].ins);
      if (pc_load === 1'b1 && first_pl < 0) first_pl = i;
      pos_half();
    end
    chk("basic_latency", first_pl - 1, 7);

    // Nesting: request while in service waits for rti_done.
    INTR_in = 1'b1; cyc(); INTR_in = 1'b0;
    s0 = n_stall;
    repeat (20) cyc();
    chk("nest_blocked_stalls", n_stall - s0, 0);
    entry_run(-1, -1, 0, 0, 0, 0, 0, 12, k);
    chk("nest_reentry_offset", k, 6);

    // Drain wait, grant stalls, masking.
    entry_run(0, -1, 0, 4, 0, 0, 0, 20, k);
    chk("drain_latency", k - 1, 11);
    entry_run(0, -1, 0, 0, 3, 2, 0, 25, k);
    chk("grant_latency", k - 1, 12);
    entry_run(0, -1, 10, 0, 0, 0, 0, 25, k);
    chk("mask_latency", k - 1, 14);

    // Two edges before acceptance give one entry.
    n0 = n_pcload;
    entry_run(0, 3, 10, 0, 0, 0, 0, 40, k);
    chk("double_edge_entries", n_pcload - n0, 1);
    chk("double_edge_latency", k - 1, 14);

    // Edge detected in the JUMP-entry cycle survives and re-enters after rti_done.
    n0 = n_pcload;
    entry_run(0, 5, 0, 0, 0, 0, 0, 16, k);
    chk("jump_edge_first", n_pcload - n0, 1);
    entry_run(-1, -1, 0, 0, 0, 0, 0, 12, k2);
    chk("jump_edge_reentry", k2, 6);

    // Reset during PUSH_FLG, with an INTR edge sampled under reset.
    rti_done = 1'b1; cyc(); rti_done = 1'b0;
    INTR_in = 1'b1; cyc(); INTR_in = 1'b0;
    rst_row = -1;
    for (int i = 0; i < 12 && rst_row < 0; i++) begin
      if (m_step == 3) begin RST = 1'b1; INTR_in = 1'b1; rst_row = i; end
      cyc();
    end
    chk("reset_reached_push_flg", rst_row >= 0, 1);
    RST = 1'b0; INTR_in = 1'b0;
    neg_half();
    chk("rst_stall", stall_fetch, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    chk("rst_in_service", in_service, 0);
    chk("rst_pc_load_val", pc_load_val, 0);
    pos_half();
    n0 = n_pcload; s0 = n_stall;
    repeat (20) cyc();
    chk("rst_no_pc_load", n_pcload - n0, 0);
    chk("rst_no_stall", n_stall - s0, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) INTR_in = ~INTR_in;
      int_en      = ($urandom_range(7) != 0);
      pipe_empty  = ($urandom_range(3) != 0);
      mif.mem_gnt = ($urandom_range(2) != 0);
      rti_done    = ($urandom_range(24) == 0);
      RST         = ($urandom_range(399) == 0);
      pc_in       = 8'($urandom);
      flags_in    = 4'($urandom);
      mif.mem_rdata = 8'($urandom);
      if ($urandom_range(63) == 0) sp_in = 8'($urandom);
      cyc();
    end
    RST = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
